// File: rtl/fifo_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_arb_pkg
// Description : Shared types and defaults for the FIFO write-port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_arb_pkg;

    localparam int N_REQ_DEF     = 4;
    localparam int DATA_W_DEF    = 4;
    localparam int MAX_BURST_DEF = 4;
    localparam int STALL_CNT_W   = 8;
    localparam int BURST_CNT_W   = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        XFER  = 2'd1,
        STALL = 2'd2
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/fifo_wr_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : fifo_wr_arbiter_if
// Description : Producer-side request bundle and FIFO write-side signals.
// Revision    : 1.0 - initial release
// ============================================================================
interface fifo_wr_arbiter_if
    import fifo_arb_pkg::*;
#(
    parameter int N_REQ  = N_REQ_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic [N_REQ-1:0]        Req;
    logic [N_REQ*DATA_W-1:0] Req_data;
    logic [N_REQ-1:0]        Req_last;
    logic                    Wr_Full;
    logic [N_REQ-1:0]        Grant;
    logic [N_REQ-1:0]        Ack;
    logic [DATA_W-1:0]       Data_in;
    logic                    Wr_en;
    logic                    Busy;
    logic [STALL_CNT_W-1:0]  Stall_cnt;

    modport master (
        output Req, Req_data, Req_last, Wr_Full,
        input  Grant, Ack, Data_in, Wr_en, Busy, Stall_cnt
    );

    modport slave (
        input  Req, Req_data, Req_last, Wr_Full,
        output Grant, Ack, Data_in, Wr_en, Busy, Stall_cnt
    );
endinterface
`default_nettype wire

// File: rtl/fifo_wr_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin picker: first set request at or
//               after the priority pointer, wrapping modulo N_REQ.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int PTR_W = 2
) (
    input  wire logic [N_REQ-1:0] Req,
    input  wire logic [PTR_W-1:0] ptr,
    output logic      [N_REQ-1:0] Grant_nxt,
    output logic                  any_req
);
    logic [PTR_W:0] w_idx;
    logic           w_found;

    always_comb begin
        Grant_nxt = '0;
        w_found   = 1'b0;
        w_idx     = '0;
        for (int k = 0; k < N_REQ; k++) begin
            // One extra bit of headroom keeps ptr+k from overflowing before the wrap
            w_idx = {1'b0, ptr} + (PTR_W+1)'(k);
            if (w_idx >= (PTR_W+1)'(N_REQ)) begin
                w_idx = w_idx - (PTR_W+1)'(N_REQ);
            end
            if (!w_found && Req[w_idx[PTR_W-1:0]]) begin
                Grant_nxt[w_idx[PTR_W-1:0]] = 1'b1;
                w_found                     = 1'b1;
            end
        end
    end

    assign any_req = |Req;

endmodule
`default_nettype wire

// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fifo_wr_arbiter
// Description : Round-robin burst arbiter sharing the FIFO write port.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int N_REQ     = N_REQ_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int MAX_BURST = MAX_BURST_DEF
) (
    input  wire logic        Wr_clk,
    input  wire logic        reset,
    fifo_wr_arbiter_if.slave bus
);
    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    arb_state_t             r_state;
    logic [N_REQ-1:0]       r_grant;
    logic [PTR_W-1:0]       r_ptr;
    logic [PTR_W-1:0]       r_owner;
    logic [BURST_CNT_W-1:0] r_burst;
    logic [STALL_CNT_W-1:0] r_stall_cnt;

    logic [N_REQ-1:0]       w_grant_nxt;
    logic                   w_any_req;
    logic [PTR_W-1:0]       w_owner_nxt;
    logic [PTR_W-1:0]       w_ptr_rot;
    logic [BURST_CNT_W-1:0] w_burst_inc;
    logic                   w_req_g;
    logic                   w_last_g;
    logic                   w_wr;
    logic                   w_end;

    rr_pick #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_rr_pick (
        .Req       (bus.Req),
        .ptr       (r_ptr),
        .Grant_nxt (w_grant_nxt),
        .any_req   (w_any_req)
    );

    always_comb begin
        w_owner_nxt = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_grant_nxt[i]) begin
                w_owner_nxt = PTR_W'(i);
            end
        end
    end

    assign w_ptr_rot   = (r_owner == PTR_W'(N_REQ-1)) ? '0 : r_owner + 1'b1;
    assign w_burst_inc = r_burst + 1'b1;
    assign w_req_g     = bus.Req[r_owner];
    assign w_last_g    = bus.Req_last[r_owner];
    // A write is gated by reset so the word presented during reset is dropped
    assign w_wr        = reset && (r_state == XFER) && w_req_g && !bus.Wr_Full;
    assign w_end       = w_last_g || (w_burst_inc == BURST_CNT_W'(MAX_BURST));

    assign bus.Wr_en     = w_wr;
    assign bus.Ack       = w_wr ? r_grant : '0;
    assign bus.Data_in   = (reset && (r_state == XFER)) ?
                           bus.Req_data[r_owner*DATA_W +: DATA_W] : '0;
    assign bus.Busy      = reset && (r_state != IDLE);
    assign bus.Grant     = r_grant;
    assign bus.Stall_cnt = r_stall_cnt;

    always_ff @(posedge Wr_clk) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_grant     <= '0;
            r_ptr       <= '0;
            r_owner     <= '0;
            r_burst     <= '0;
            r_stall_cnt <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_any_req) begin
                        r_grant <= w_grant_nxt;
                        r_owner <= w_owner_nxt;
                        r_burst <= '0;
                        r_state <= XFER;
                    end
                end
                XFER: begin
                    if (!w_req_g) begin
                        r_state <= IDLE;
                        r_grant <= '0;
                        r_ptr   <= w_ptr_rot;
                    end else if (bus.Wr_Full) begin
                        r_state <= STALL;
                    end else begin
                        r_burst <= w_burst_inc;
                        if (w_end) begin
                            r_state <= IDLE;
                            r_grant <= '0;
                            r_ptr   <= w_ptr_rot;
                        end
                    end
                end
                STALL: begin
                    if (r_stall_cnt != '1) begin
                        r_stall_cnt <= r_stall_cnt + 1'b1;
                    end
                    if (!w_req_g) begin
                        r_state <= IDLE;
                        r_grant <= '0;
                        r_ptr   <= w_ptr_rot;
                    end else if (!bus.Wr_Full) begin
                        r_state <= XFER;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_grant <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_wr_arbiter
// Description : Directed scoreboard bench for the FIFO write-port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_wr_arbiter;
    import fifo_arb_pkg::*;

    localparam int N  = 4;
    localparam int DW = 4;
    localparam int MB = 4;

    typedef struct packed {
        logic [1:0] idx;
        logic [3:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fifo_wr_arbiter_if #(.N_REQ(N), .DATA_W(DW)) bus ();

    fifo_wr_arbiter #(
        .N_REQ     (N),
        .DATA_W    (DW),
        .MAX_BURST (MB)
    ) dut (
        .Wr_clk (clk),
        .reset  (reset),
        .bus    (bus)
    );

    exp_t exp_q[$];
    exp_t mon_e;
    int   errors   = 0;
    int   checks   = 0;
    int   wr_count = 0;
    bit   mon_en   = 1'b0;
    int   base;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int idx, input int data, input int n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back('{idx: 2'(idx), data: 4'(data)});
        end
    endtask

    // Monitor: every FIFO write must match the oldest expected word
    always @(negedge clk) begin
        if (mon_en) begin
            check("grant_onehot", {31'd0, $onehot0(bus.Grant)}, 32'd1);
            if (bus.Wr_en) begin
                wr_count++;
                check("wr_while_full", {31'd0, bus.Wr_Full}, 32'd0);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: ack=%b data=%h with empty scoreboard", bus.Ack, bus.Data_in);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("ack", {28'd0, bus.Ack}, 32'd1 << mon_e.idx);
                    check("data", {28'd0, bus.Data_in}, {28'd0, mon_e.data});
                end
            end else begin
                check("ack_no_write", {28'd0, bus.Ack}, 32'd0);
            end
        end
    end

    initial begin
        reset        = 1'b0;
        bus.Req      = '0;
        bus.Req_data = '0;
        bus.Req_last = '0;
        bus.Wr_Full  = 1'b0;
        tick();
        tick();
        check("rst_grant", {28'd0, bus.Grant}, 32'd0);
        check("rst_busy", {31'd0, bus.Busy}, 32'd0);
        check("rst_wr_en", {31'd0, bus.Wr_en}, 32'd0);
        check("rst_data_in", {28'd0, bus.Data_in}, 32'd0);
        check("rst_stall_cnt", {24'd0, bus.Stall_cnt}, 32'd0);
        reset  = 1'b1;
        mon_en = 1'b1;

        // Single requester, last on the 3rd word
        bus.Req_data = 16'h000A;
        bus.Req      = 4'b0001;
        push(0, 4'hA, 3);
        tick();
        check("t1_grant", {28'd0, bus.Grant}, 32'h1);
        check("t1_busy", {31'd0, bus.Busy}, 32'd1);
        tick();
        tick();
        bus.Req_last = 4'b0001;
        tick();
        check("t1_idle_grant", {28'd0, bus.Grant}, 32'd0);
        check("t1_idle_busy", {31'd0, bus.Busy}, 32'd0);
        check("t1_words", wr_count, 32'd3);
        bus.Req_last = '0;
        bus.Req      = 4'b0011;
        tick();
        check("t1_ptr_rot", {28'd0, bus.Grant}, 32'h2);
        bus.Req = '0;
        tick();
        check("t1_abandon_grant", {28'd0, bus.Grant}, 32'd0);

        // All four requesting continuously, never last
        reset = 1'b0;
        tick();
        reset        = 1'b1;
        bus.Req_data = 16'h8421;
        bus.Req      = 4'b1111;
        push(0, 1, 4);
        push(1, 2, 4);
        push(2, 4, 4);
        push(3, 8, 4);
        push(0, 1, 4);
        tick();
        base = wr_count;
        for (int c = 1; c <= 24; c++) begin
            if (c == 21) check("t2_duty_4_of_5", wr_count - base, 32'd16);
            check("t2_grant_seq", {28'd0, bus.Grant},
                  (((c - 1) % 5) < 4) ? (32'd1 << (((c - 1) / 5) % 4)) : 32'd0);
            tick();
        end
        bus.Req = '0;
        check("t2_words", wr_count - base, 32'd20);
        tick();

        // Full stall on requester 1 after its 2nd word
        bus.Req = 4'b0110;
        push(1, 2, 4);
        tick();
        tick();
        tick();
        bus.Wr_Full = 1'b1;
        base = wr_count;
        repeat (6) tick();
        bus.Wr_Full = 1'b0;
        check("t3_no_write_full", wr_count - base, 32'd0);
        tick();
        check("t3_no_write_release", wr_count - base, 32'd0);
        check("t3_stall_cnt", {24'd0, bus.Stall_cnt}, 32'd6);
        check("t3_grant_held", {28'd0, bus.Grant}, 32'h2);
        tick();
        tick();
        check("t3_burst_end", {28'd0, bus.Grant}, 32'd0);
        check("t3_words", wr_count - base, 32'd2);

        // Requester 2 abandons while stalled; requester 3 follows
        bus.Wr_Full = 1'b1;
        tick();
        check("t4_grant2", {28'd0, bus.Grant}, 32'h4);
        tick();
        check("t4_stall_busy", {31'd0, bus.Busy}, 32'd1);
        bus.Req = 4'b1001;
        tick();
        check("t4_abandon_idle", {28'd0, bus.Grant}, 32'd0);
        check("t4_stall_cnt", {24'd0, bus.Stall_cnt}, 32'd7);
        bus.Wr_Full  = 1'b0;
        bus.Req_last = 4'b1000;
        push(3, 8, 1);
        tick();
        check("t4_grant3", {28'd0, bus.Grant}, 32'h8);
        tick();
        check("t4_end", {28'd0, bus.Grant}, 32'd0);
        bus.Req      = '0;
        bus.Req_last = '0;

        // Reset during requester 0's 2nd word
        bus.Req = 4'b0011;
        push(0, 1, 1);
        tick();
        tick();
        reset = 1'b0;
        #1;
        check("t5_rst_wr_en", {31'd0, bus.Wr_en}, 32'd0);
        check("t5_rst_ack", {28'd0, bus.Ack}, 32'd0);
        check("t5_rst_data", {28'd0, bus.Data_in}, 32'd0);
        check("t5_rst_busy", {31'd0, bus.Busy}, 32'd0);
        tick();
        reset = 1'b1;
        check("t5_post_grant", {28'd0, bus.Grant}, 32'd0);
        check("t5_post_stall_cnt", {24'd0, bus.Stall_cnt}, 32'd0);
        bus.Req_last = 4'b0001;
        push(0, 1, 1);
        tick();
        check("t5_regrant0", {28'd0, bus.Grant}, 32'h1);
        tick();
        bus.Req      = '0;
        bus.Req_last = '0;
        check("t5_end", {28'd0, bus.Grant}, 32'd0);

        // Stall counter saturation
        bus.Wr_Full = 1'b1;
        bus.Req     = 4'b0100;
        tick();
        base = wr_count;
        repeat (300) tick();
        check("t6_stall_sat", {24'd0, bus.Stall_cnt}, 32'd255);
        check("t6_grant_held", {28'd0, bus.Grant}, 32'h4);
        check("t6_busy", {31'd0, bus.Busy}, 32'd1);
        check("t6_no_write", wr_count - base, 32'd0);
        bus.Wr_Full  = 1'b0;
        bus.Req_last = 4'b0100;
        push(2, 4, 1);
        tick();
        tick();
        check("t6_end", {28'd0, bus.Grant}, 32'd0);
        bus.Req      = '0;
        bus.Req_last = '0;
        tick();
        check("queue_drained", exp_q.size(), 32'd0);

        mon_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
